// File: rtl/tpu_vector_unpacker.sv
// Drains one 256-bit Float8 result vector as 32 single-byte beats, lane 0 first.
// Optional sticky overflow status is enabled with `define TPU_UNPACK_STICKY_OVF_EN.
module tpu_vector_unpacker #(
  parameter int LANES = 32,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     vec_valid,
  output logic                     vec_ready,
  input  logic [LANES*WIDTH-1:0]   vec_data,
  input  logic                     vec_ovf,
  output logic                     lane_valid,
  input  logic                     lane_ready,
`ifdef TPU_UNPACK_STICKY_OVF_EN
  input  logic                     ovf_clr,
  output logic                     ovf_sticky,
`endif
  output logic [WIDTH-1:0]         lane_data,
  output logic [$clog2(LANES)-1:0] lane_idx,
  output logic                     lane_last,
  output logic                     lane_ovf
);

  localparam int IDX_W = $clog2(LANES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                   state_reg, state_next;
  logic [LANES*WIDTH-1:0]   buf_reg, buf_next, buf_shift;
  logic [IDX_W-1:0]         idx_reg, idx_next;
  logic                     ovf_reg, ovf_next;
  logic                     accept, beat, at_last;

  // Lane-wise right shift by one lane with zero fill at the top.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_shift
      if (gi == LANES - 1) begin : g_top
        assign buf_shift[WIDTH*gi +: WIDTH] = '0;
      end else begin : g_mid
        assign buf_shift[WIDTH*gi +: WIDTH] = buf_reg[WIDTH*(gi+1) +: WIDTH];
      end
    end
  endgenerate

  assign at_last    = (state_reg == STREAM) && (idx_reg == LAST_IDX);
  assign lane_valid = (state_reg == STREAM);
  assign lane_data  = buf_reg[WIDTH-1:0];
  assign lane_idx   = idx_reg;
  assign lane_last  = at_last;
  assign lane_ovf   = at_last & ovf_reg;
  assign beat       = lane_valid & lane_ready;
  // Reload is allowed on the final beat so vectors stream without a bubble.
  assign vec_ready  = (state_reg == IDLE) | (at_last & lane_ready);
  assign accept     = vec_valid & vec_ready;

  always_comb begin
    state_next = state_reg;
    buf_next   = buf_reg;
    idx_next   = idx_reg;
    ovf_next   = ovf_reg;
    if (accept) begin
      state_next = STREAM;
      buf_next   = vec_data;
      idx_next   = '0;
      ovf_next   = vec_ovf;
    end else if (beat) begin
      if (at_last) begin
        state_next = IDLE;
        buf_next   = '0;
        idx_next   = '0;
        ovf_next   = 1'b0;
      end else begin
        buf_next = buf_shift;
        idx_next = idx_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      buf_reg   <= '0;
      idx_reg   <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      buf_reg   <= buf_next;
      idx_reg   <= idx_next;
      ovf_reg   <= ovf_next;
    end
  end

`ifdef TPU_UNPACK_STICKY_OVF_EN
  logic sticky_reg, sticky_next;

  // Set has priority so a clear cannot hide an overflow arriving the same cycle.
  always_comb begin
    sticky_next = sticky_reg;
    if (ovf_clr) sticky_next = 1'b0;
    if (accept && vec_ovf) sticky_next = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sticky_reg <= 1'b0;
    else        sticky_reg <= sticky_next;
  end

  assign ovf_sticky = sticky_reg;
`endif

endmodule

// File: tb/tb_tpu_vector_unpacker.sv
// Randomized self-checking bench for tpu_vector_unpacker; expected beats are
// derived directly from the lane packing rule (lane i = bits [8i+7:8i]).
module tb_tpu_vector_unpacker;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         vec_valid;
  logic         vec_ready;
  logic [255:0] vec_data;
  logic         vec_ovf;
  logic         lane_valid;
  logic         lane_ready;
  logic [7:0]   lane_data;
  logic [4:0]   lane_idx;
  logic         lane_last;
  logic         lane_ovf;
`ifdef TPU_UNPACK_STICKY_OVF_EN
  logic         ovf_clr;
  logic         ovf_sticky;
`endif

  int checks = 0;
  int passed = 0;

  tpu_vector_unpacker dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .vec_valid  (vec_valid),
    .vec_ready  (vec_ready),
    .vec_data   (vec_data),
    .vec_ovf    (vec_ovf),
    .lane_valid (lane_valid),
    .lane_ready (lane_ready),
`ifdef TPU_UNPACK_STICKY_OVF_EN
    .ovf_clr    (ovf_clr),
    .ovf_sticky (ovf_sticky),
`endif
    .lane_data  (lane_data),
    .lane_idx   (lane_idx),
    .lane_last  (lane_last),
    .lane_ovf   (lane_ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] rand_vec();
    logic [255:0] r;
    for (int w = 0; w < 8; w++) r[32*w +: 32] = $urandom;
    return r;
  endfunction

  // Reference: beat k of a vector carries byte k of the packed word.
  function automatic logic [15:0] exp_beat(input logic [255:0] v, input int k, input logic ovf);
    logic [7:0] b;
    b = 8'((v >> (8 * k)) & 256'hFF);
    return {1'b1, b, 5'(k), (k == 31), (k == 31) & ovf};
  endfunction

  function automatic logic [15:0] obs_beat();
    return {lane_valid, lane_data, lane_idx, lane_last, lane_ovf};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; vec_valid = 1'b0; vec_data = '0; vec_ovf = 1'b0; lane_ready = 1'b0;
`ifdef TPU_UNPACK_STICKY_OVF_EN
    ovf_clr = 1'b0;
`endif
    #1;
    checks++;
    if ({obs_beat(), vec_ready} !== 17'h0001)
      $display("FAIL reset_state: got %h want %h", {obs_beat(), vec_ready}, 17'h0001);
    else passed++;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_sequential();
    logic [255:0] v;
    for (int i = 0; i < 32; i++) v[8*i +: 8] = 8'(i);
    vec_valid = 1'b1; vec_data = v; vec_ovf = 1'b0; lane_ready = 1'b1;
    #1;
    checks++;
    if (vec_ready !== 1'b1) $display("FAIL seq_idle_ready: got %b want 1", vec_ready);
    else passed++;
    @(negedge clk);
    vec_valid = 1'b0;
    for (int k = 0; k < 32; k++) begin
      #1;
      checks++;
      if (obs_beat() !== exp_beat(v, k, 1'b0))
        $display("FAIL seq_beat%0d: got %h want %h", k, obs_beat(), exp_beat(v, k, 1'b0));
      else passed++;
      @(negedge clk);
    end
    #1;
    checks++;
    if ({lane_valid, vec_ready} !== 2'b01)
      $display("FAIL seq_back_idle: got %b want 01", {lane_valid, vec_ready});
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [255:0] a, b;
    a = {32{8'hA5}}; b = {32{8'h3C}};
    @(negedge clk);
    vec_valid = 1'b1; vec_data = a; vec_ovf = 1'b0; lane_ready = 1'b1;
    @(negedge clk);
    vec_data = b;
    for (int c = 0; c < 64; c++) begin
      #1;
      checks++;
      if (obs_beat() !== exp_beat((c < 32) ? a : b, c % 32, 1'b0))
        $display("FAIL b2b_beat%0d: got %h want %h", c, obs_beat(), exp_beat((c < 32) ? a : b, c % 32, 1'b0));
      else passed++;
      if (c == 31) begin
        checks++;
        if (vec_ready !== 1'b1) $display("FAIL b2b_reload_ready: got %b want 1", vec_ready);
        else passed++;
      end
      @(negedge clk);
      if (c == 31) vec_valid = 1'b0;
    end
    #1;
    checks++;
    if (lane_valid !== 1'b0) $display("FAIL b2b_end_idle: got %b want 0", lane_valid);
    else passed++;
  endtask

  task automatic test_stall();
    logic [255:0] v;
    int k;
    int cyc;
    logic [3:0] pat;
    v = rand_vec();
    pat = 4'b1001;
    @(negedge clk);
    vec_valid = 1'b1; vec_data = v; vec_ovf = 1'b1; lane_ready = 1'b0;
    @(negedge clk);
    vec_valid = 1'b0;
    k = 0; cyc = 0;
    while (k < 32 && cyc < 200) begin
      lane_ready = pat[3 - (cyc % 4)];
      #1;
      checks++;
      if (obs_beat() !== exp_beat(v, k, 1'b1))
        $display("FAIL stall_cyc%0d: got %h want %h", cyc, obs_beat(), exp_beat(v, k, 1'b1));
      else passed++;
      if (lane_ready) k++;
      cyc++;
      @(negedge clk);
    end
    lane_ready = 1'b1;
    #1;
    checks++;
    if (k != 32 || lane_valid !== 1'b0)
      $display("FAIL stall_done: got beats %0d valid %b want 32 0", k, lane_valid);
    else passed++;
  endtask

  task automatic test_hold_off();
    logic [255:0] v1, v2;
    v1 = rand_vec(); v2 = rand_vec();
    @(negedge clk);
    vec_valid = 1'b1; vec_data = v1; vec_ovf = 1'b0; lane_ready = 1'b1;
    @(negedge clk);
    vec_valid = 1'b0;
    for (int k = 0; k < 32; k++) begin
      if (k == 10) begin vec_valid = 1'b1; vec_data = v2; vec_ovf = 1'b1; end
      #1;
      checks++;
      if (obs_beat() !== exp_beat(v1, k, 1'b0))
        $display("FAIL hold_v1_beat%0d: got %h want %h", k, obs_beat(), exp_beat(v1, k, 1'b0));
      else passed++;
      if (k >= 10) begin
        checks++;
        if (vec_ready !== (k == 31))
          $display("FAIL hold_ready%0d: got %b want %b", k, vec_ready, (k == 31));
        else passed++;
      end
      @(negedge clk);
    end
    vec_valid = 1'b0;
    for (int k = 0; k < 32; k++) begin
      #1;
      checks++;
      if (obs_beat() !== exp_beat(v2, k, 1'b1))
        $display("FAIL hold_v2_beat%0d: got %h want %h", k, obs_beat(), exp_beat(v2, k, 1'b1));
      else passed++;
      @(negedge clk);
    end
  endtask

  task automatic test_async_reset();
    logic [255:0] v1, v2;
    v1 = rand_vec(); v2 = rand_vec();
    @(negedge clk);
    vec_valid = 1'b1; vec_data = v1; vec_ovf = 1'b1; lane_ready = 1'b1;
    @(negedge clk);
    vec_valid = 1'b0;
    for (int k = 0; k < 17; k++) @(negedge clk);
    #1;
    checks++;
    if (obs_beat() !== exp_beat(v1, 17, 1'b1))
      $display("FAIL arst_pre: got %h want %h", obs_beat(), exp_beat(v1, 17, 1'b1));
    else passed++;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({obs_beat(), vec_ready} !== 17'h0001)
      $display("FAIL arst_abort: got %h want %h", {obs_beat(), vec_ready}, 17'h0001);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vec_valid = 1'b1; vec_data = v2; vec_ovf = 1'b0;
    @(negedge clk);
    vec_valid = 1'b0;
    for (int k = 0; k < 32; k++) begin
      #1;
      checks++;
      if (obs_beat() !== exp_beat(v2, k, 1'b0))
        $display("FAIL arst_after_beat%0d: got %h want %h", k, obs_beat(), exp_beat(v2, k, 1'b0));
      else passed++;
      @(negedge clk);
    end
  endtask

`ifdef TPU_UNPACK_STICKY_OVF_EN
  task automatic test_sticky();
    logic [2:0] ovf_seq, clr_seq, want;
    ovf_seq = 3'b101; clr_seq = 3'b001; want = 3'b111;
    lane_ready = 1'b1;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      vec_valid = 1'b1; vec_data = rand_vec(); vec_ovf = ovf_seq[2 - s]; ovf_clr = clr_seq[2 - s];
      @(negedge clk);
      vec_valid = 1'b0; ovf_clr = 1'b0;
      #1;
      checks++;
      if (ovf_sticky !== want[2 - s])
        $display("FAIL sticky_step%0d: got %b want %b", s, ovf_sticky, want[2 - s]);
      else passed++;
      for (int k = 0; k < 32; k++) @(negedge clk);
    end
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    #1;
    checks++;
    if (ovf_sticky !== 1'b0) $display("FAIL sticky_clear: got %b want 0", ovf_sticky);
    else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_sequential();
    test_back_to_back();
    test_stall();
    test_hold_off();
    test_async_reset();
`ifdef TPU_UNPACK_STICKY_OVF_EN
    test_sticky();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/tpu_vector_unpacker.md
# tpu_vector_unpacker

Sequential unpacker on the output side of the 32-lane Float8 vector adder. Accepts one 256-bit result vector plus its OR-reduced overflow flag, then streams the 32 Float8 lanes out one byte per beat, lane 0 first, over a valid/ready handshake to the result writer. It is the read/drain end of the vector datapath, mirroring the lane packing the adder uses (lane i = bits [8i+7:8i]).

## Interface
- LANES, 32, number of Float8 lanes per vector
- WIDTH, 8, bits per lane
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- vec_valid  input  1  upstream vector available
- vec_ready  output  1  unpacker can accept a vector this cycle
- vec_data  input  LANES*WIDTH  packed vector, lane i at [WIDTH*i+WIDTH-1:WIDTH*i]
- vec_ovf  input  1  overflow flag belonging to vec_data
- lane_valid  output  1  lane_data valid
- lane_ready  input  1  downstream accepts lane
- lane_data  output  WIDTH  current Float8 lane
- lane_idx  output  $clog2(LANES)  index of current lane
- lane_last  output  1  current lane is LANES-1
- lane_ovf  output  1  vector overflow flag, valid only on the last beat, 0 otherwise
- ovf_sticky  output  1  (only with TPU_UNPACK_STICKY_OVF_EN) sticky overflow status
- ovf_clr  input  1  (only with TPU_UNPACK_STICKY_OVF_EN) synchronous clear of ovf_sticky

## Operation
- States: IDLE, STREAM. Reset -> IDLE.
- Reset values: lane_valid 0, lane_data 0, lane_idx 0, lane_last 0, lane_ovf 0, ovf_sticky 0; vec_ready 1 (IDLE).
- vec_ready = (state==IDLE) | (state==STREAM & lane_last & lane_ready). Combinational lane_ready -> vec_ready path is intended.
- Accept = vec_valid & vec_ready: load vec_data into LANES*WIDTH shift buffer, latch vec_ovf, lane_idx <= 0, state <= STREAM.
- STREAM: lane_valid=1; lane_data = buffer[WIDTH-1:0]; beat = lane_valid & lane_ready.
- On beat, not last: buffer shifts right by WIDTH (zero fill), lane_idx+1.
- On beat at lane_idx==LANES-1: if accept same cycle, reload and stay STREAM (back-to-back, no bubble); else -> IDLE, lane_valid 0.
- lane_ready with lane_valid=0 ignored. vec_valid in STREAM before last beat not accepted (vec_ready 0); upstream must hold.
- lane_data, lane_idx, lane_last, lane_ovf stable while lane_valid & !lane_ready.
- rst_n low mid-stream: immediate abort, remaining lanes dropped, all outputs to reset values.

## Timing
- Accept in cycle N -> lane 0 valid in cycle N+1 (registered).
- Full throughput: 32 beats per vector with lane_ready held 1, back-to-back vectors with no idle cycle.
- Isolated vector: IDLE->accept->32 beats->IDLE; vec_ready high again the cycle after the last beat.
- No combinational path from vec_* inputs to lane_* outputs.

## Configuration
- TPU_UNPACK_STICKY_OVF_EN defined: ovf_sticky/ovf_clr ports present; ovf_sticky sets to 1 on the clock edge of an accept with vec_ovf=1, clears on ovf_clr=1; set wins over clear in the same cycle; reset value 0.
- Undefined: both ports absent, no sticky register; lane_ovf behaviour unchanged.

## Test plan
- Vector with lane i = i (0x00..0x1F), vec_ovf 0, lane_ready=1 -> lane_data 0x00..0x1F on 32 consecutive cycles, lane_idx 0..31, lane_last only at idx 31, lane_ovf 0.
- Two vectors back-to-back (lanes 0xA5 all, then 0x3C all), vec_valid held -> 64 contiguous beats, second vector accepted on first vector's last beat, no bubble.
- lane_ready toggled 1,0,0,1 pattern on vector with vec_ovf 1 -> lane_data/lane_idx held during stalls, every lane delivered exactly once, lane_ovf 1 only on idx 31 beat.
- vec_valid asserted with new data at idx 10 of a stream -> vec_ready 0, new vector not loaded until last beat; current lanes unaffected.
- rst_n pulsed low at idx 17 -> lane_valid 0, lane_idx 0, vec_ready 1 asynchronously; next vector streams from lane 0.
- With TPU_UNPACK_STICKY_OVF_EN: accept vec_ovf 1 -> ovf_sticky 1 next cycle; accept vec_ovf 0 -> stays 1; ovf_clr coincident with vec_ovf-1 accept -> stays 1; ovf_clr alone -> 0.
